// File: rtl/mem48_byte_loader.sv
// mem48_byte_loader
// Packs a byte stream little-endian into 48-bit words, writes each word to the
// attached memory in one cycle, then reads it back through the memory's
// combinational read port and flags any mismatch. Owns the memory address,
// write strobe and write data while a load is in progress.
module mem48_byte_loader #(
  parameter int WORDS = 16384,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [47:0]   mem_wdata,
  input  logic [47:0]   mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    VERIFY = 2'd3
  } state_t;

  state_t        state_r, state_n;
  logic [AW-1:0] cur_addr_r, cur_addr_n;
  logic [AW:0]   remaining_r, remaining_n;
  logic [2:0]    byte_idx_r, byte_idx_n;
  logic [47:0]   asm_r, asm_n;
  logic          error_r, error_n;
  logic          done_r, done_n;
  logic          in_ready_r;
  logic          mem_we_r;
  logic [47:0]   mem_wdata_r;
  logic          busy_r;

  // Advance a word index, wrapping modulo WORDS so non-power-of-two depths work.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    if (a == AW'(WORDS - 1)) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = a + AW'(1);
    end
  endfunction

  // Next-state logic: operand latching, byte packing, readback check, completion.
  always_comb begin
    state_n     = state_r;
    cur_addr_n  = cur_addr_r;
    remaining_n = remaining_r;
    byte_idx_n  = byte_idx_r;
    asm_n       = asm_r;
    error_n     = error_r;
    done_n      = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          error_n    = 1'b0;
          byte_idx_n = 3'd0;
          if (word_count != '0) begin
            cur_addr_n  = base_addr;
            remaining_n = word_count;
            state_n     = RECV;
          end else begin
            // Empty load completes at once without touching memory.
            done_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end

      RECV: begin
        // in_ready is high throughout RECV, so in_valid alone marks a transfer.
        if (in_valid) begin
          asm_n[{byte_idx_r, 3'b000} +: 8] = in_data;
          if (byte_idx_r == 3'd5) begin
            byte_idx_n = 3'd0;
            state_n    = WRITE;
          end else begin
            byte_idx_n = byte_idx_r + 3'd1;
          end
        end else begin
          state_n = RECV;
        end
      end

      WRITE: begin
        state_n = VERIFY;
      end

      VERIFY: begin
        // A mismatch is recorded but the load carries on.
        if (mem_rdata != asm_r) begin
          error_n = 1'b1;
        end else begin
          error_n = error_r;
        end
        cur_addr_n  = wrap_inc(cur_addr_r);
        remaining_n = remaining_r - (AW+1)'(1);
        if (remaining_r == (AW+1)'(1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = RECV;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      byte_idx_r  <= 3'd0;
      asm_r       <= 48'd0;
      error_r     <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 48'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cur_addr_r  <= cur_addr_n;
      remaining_r <= remaining_n;
      byte_idx_r  <= byte_idx_n;
      asm_r       <= asm_n;
      error_r     <= error_n;
      done_r      <= done_n;
      in_ready_r  <= (state_n == RECV);
      mem_we_r    <= (state_n == WRITE);
      mem_wdata_r <= (state_n == WRITE) ? asm_n : 48'd0;
      busy_r      <= (state_n != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_addr  = cur_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_mem48_byte_loader.sv
// Scoreboard bench for mem48_byte_loader: stimulus pushes expected writes and
// done events into queues, a monitor pops and compares them as the DUT acts.
module tb_mem48_byte_loader;

  localparam int WORDS = 16384;
  localparam int AW    = 14;
  localparam logic [47:0] SENT = 48'hA5A5_A5A5_A5A5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [47:0]   mem_wdata;
  logic [47:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [47:0]   data;
  } wr_t;

  typedef struct {
    bit err;
    int delta;
  } dn_t;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ref_cyc = 0;
  bit   corrupt = 1'b0;
  logic [47:0] mem [0:WORDS-1];

  mem48_byte_loader #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, combinational read, optional bit-47 fault on word 0.
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = SENT;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr] ^ ((corrupt && mem_addr == '0) ? 48'h8000_0000_0000 : 48'h0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every write and done pulse against the scoreboard queues.
  initial begin
    bit  prev_we;
    wr_t w;
    dn_t d;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_we) chk("ready_in_verify", {63'd0, in_ready}, 64'd0);
      if (mem_we) begin
        chk("ready_in_write", {63'd0, in_ready}, 64'd0);
        chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("write_addr", {50'd0, mem_addr}, {50'd0, w.addr});
          chk("write_data", {16'd0, mem_wdata}, {16'd0, w.data});
        end
      end
      if (done) begin
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        if (exp_dn.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          d = exp_dn.pop_front();
          chk("done_error", {63'd0, error}, {63'd0, d.err});
          chk("done_latency", 64'(cyc - ref_cyc), 64'(d.delta));
        end
      end
      prev_we = mem_we;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 64'd0);
    chk({tag, "_mem_addr"}, {50'd0, mem_addr}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  // Offer one byte until accepted; ref_cyc becomes the cycle count after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit v;
    bit sent;
    sent = 1'b0;
    for (int t = 0; t < 200 && !sent; t++) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = b;
      if (v && in_ready) begin
        ref_cyc = cyc + 1;
        sent = 1'b1;
      end
    end
    if (!sent) chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [47:0] pack_word(input int seed, input int k);
    logic [47:0] w;
    for (int j = 0; j < 6; j++) w[8*j +: 8] = 8'(seed + 6*k + j);
    return w;
  endfunction

  task automatic issue_start(input int base, input int count);
    @(negedge clk);
    base_addr  = AW'(base);
    word_count = (AW+1)'(count);
    start      = 1'b1;
    ref_cyc    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int base, input int count, input bit gaps,
                          input bit exp_err, input bit probe_err, input int seed);
    dn_t d;
    wr_t w;
    d.err = exp_err;
    d.delta = (count == 0) ? 0 : 2;
    exp_dn.push_back(d);
    issue_start(base, count);
    if (count == 0) begin
      for (int i = 0; i < 3; i++) begin
        chk("zero_busy", {63'd0, busy}, 64'd0);
        chk("zero_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
      end
    end else begin
      for (int k = 0; k < count; k++) begin
        w.addr = AW'((base + k) % WORDS);
        w.data = pack_word(seed, k);
        exp_wr.push_back(w);
        for (int j = 0; j < 6; j++) send_byte(w.data[8*j +: 8], gaps);
        if (probe_err && k == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
          @(negedge clk);
          @(negedge clk);
          chk("error_after_w0", {63'd0, error}, 64'd1);
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_dn.size()), 64'd0);
  endtask

  initial begin
    wr_t w;
    logic [47:0] w1;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: single word, back-to-back bytes 01..06
    run_load(5, 1, 1'b0, 1'b0, 1'b0, 1);
    chk("t1_mem5", {16'd0, mem[5]}, {16'd0, 48'h060504030201});

    // 3: wrap from the last index to 0
    run_load(WORDS - 1, 2, 1'b0, 1'b0, 1'b0, 32'h20);
    chk("t3_mem_last", {16'd0, mem[WORDS-1]}, {16'd0, 48'h252423222120});
    chk("t3_mem0", {16'd0, mem[0]}, {16'd0, 48'h2b2a29282726});
    chk("t3_mem1_untouched", {16'd0, mem[1]}, {16'd0, SENT});

    // 4: zero-length load
    run_load(7, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_mem7_untouched", {16'd0, mem[7]}, {16'd0, SENT});

    // 2: three words with random valid gaps
    run_load(0, 3, 1'b1, 1'b0, 1'b0, 32'h80);
    chk("t2_mem0", {16'd0, mem[0]}, {16'd0, 48'h858483828180});
    chk("t2_mem1", {16'd0, mem[1]}, {16'd0, 48'h8b8a89888786});
    chk("t2_mem2", {16'd0, mem[2]}, {16'd0, 48'h91908f8e8d8c});

    // 5: reset after 3 bytes of word 2 of a 4-word load
    w1 = pack_word(32'h40, 0);
    w.addr = AW'(100);
    w.data = w1;
    exp_wr.push_back(w);
    issue_start(100, 4);
    for (int j = 0; j < 6; j++) send_byte(w1[8*j +: 8], 1'b0);
    for (int j = 0; j < 3; j++) send_byte(8'(8'h50 + j), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    chk("t5_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("t5_word1_kept", {16'd0, mem[100]}, {16'd0, 48'h454443424140});
    chk("t5_word2_absent", {16'd0, mem[101]}, {16'd0, SENT});
    run_load(110, 1, 1'b0, 1'b0, 1'b0, 32'h60);
    chk("t5_reload", {16'd0, mem[110]}, {16'd0, 48'h656463626160});

    // 6: readback fault on word 0, then a clean load clears error
    corrupt = 1'b1;
    run_load(0, 2, 1'b0, 1'b1, 1'b1, 32'hC0);
    corrupt = 1'b0;
    chk("t6_mem1", {16'd0, mem[1]}, {16'd0, 48'hcbcac9c8c7c6});
    chk("t6_error_sticky", {63'd0, error}, 64'd1);
    run_load(200, 1, 1'b0, 1'b0, 1'b0, 32'h10);
    chk("t6_error_cleared", {63'd0, error}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
